voice_envelope: RTL and testbench

VOICE_ENVELOPE -- requirements
Module: voice_envelope

---
 rtl/voice_envelope.sv | 173 +++++++++++++++++
 tb/tb_voice_envelope.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/voice_envelope.sv
// Single-voice ADSR-style envelope: tick-paced attack/sustain/decay gain applied
// to an 8-bit voice sample, with a registered scaled output.
module voice_envelope #(
  parameter int unsigned TICK_DIV      = 1250,
  parameter int unsigned ATTACK_STEP   = 4,
  parameter int unsigned DECAY_STEP    = 1,
  parameter int unsigned SUSTAIN_TICKS = 400
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] note_in,
  input  logic       key_on,
  output logic [7:0] wave_out,
  output logic [7:0] gain,
  output logic [1:0] state,
  output logic       active
);

  localparam int unsigned TICK_W = 16;
  localparam int unsigned SUST_W = 16;
  localparam int unsigned GAIN_W = 8;
  localparam int unsigned EXT_W  = GAIN_W + 1;

  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [SUST_W-1:0] SUST_LOAD  = SUST_W'(SUSTAIN_TICKS);
  localparam logic [EXT_W-1:0]  ATTACK_INC = EXT_W'(ATTACK_STEP);
  localparam logic [EXT_W-1:0]  DECAY_DEC  = EXT_W'(DECAY_STEP);
  localparam logic [EXT_W-1:0]  GAIN_FULL  = EXT_W'(255);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ATTACK  = 2'b01,
    ST_SUSTAIN = 2'b10,
    ST_DECAY   = 2'b11
  } state_e;

  state_e              state_q, state_d;
  logic [TICK_W-1:0]   tick_cnt_q;
  logic [SUST_W-1:0]   sust_q, sust_d;
  logic [GAIN_W-1:0]   gain_q, gain_d;
  logic [GAIN_W-1:0]   wave_q, wave_d;
  logic                key_q;
  logic                active_q;

  logic                tick_c, rise_c, fall_c;
  logic [EXT_W-1:0]    attack_sum_c, decay_diff_c;
  logic [GAIN_W-1:0]   attack_gain_c, decay_gain_c;
  logic                attack_full_c, decay_zero_c;
  logic                sust_last_c;

  assign tick_c = (tick_cnt_q == TICK_LAST);
  assign rise_c = key_on & ~key_q;
  assign fall_c = ~key_on & key_q;

  // Saturating gain arithmetic in 9 bits; bit 8 flags overflow / borrow.
  assign attack_sum_c  = {1'b0, gain_q} + ATTACK_INC;
  assign attack_full_c = (attack_sum_c >= GAIN_FULL);
  assign attack_gain_c = attack_full_c ? 8'hFF : attack_sum_c[GAIN_W-1:0];
  assign decay_diff_c  = {1'b0, gain_q} - DECAY_DEC;
  assign decay_zero_c  = decay_diff_c[EXT_W-1] | (decay_diff_c[GAIN_W-1:0] == 8'd0);
  assign decay_gain_c  = decay_zero_c ? 8'd0 : decay_diff_c[GAIN_W-1:0];
  assign sust_last_c   = (sust_q <= SUST_W'(1));

  // Upper byte of note*gain: full-scale sample at full gain gives 254.
  assign wave_d = GAIN_W'((16'(note_in) * 16'(gain_q)) >> 8);

  // Free-running step timer, independent of key and state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt_q <= '0;
    end else if (tick_c) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= TICK_W'(tick_cnt_q + TICK_W'(1));
    end
  end

  // Key history for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_q <= 1'b0;
    end else begin
      key_q <= key_on;
    end
  end

  // Envelope state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; key edges take priority over a coincident tick.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (rise_c) state_d = ST_ATTACK;
      end
      ST_ATTACK: begin
        if (fall_c)                       state_d = ST_DECAY;
        else if (tick_c && attack_full_c) state_d = ST_SUSTAIN;
      end
      ST_SUSTAIN: begin
        if (fall_c)                          state_d = ST_DECAY;
        else if (!rise_c && tick_c && sust_last_c) state_d = ST_DECAY;
      end
      ST_DECAY: begin
        if (rise_c)                      state_d = ST_ATTACK;
        else if (tick_c && decay_zero_c) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Gain and sustain-counter updates; a transition cycle suppresses the step.
  always_comb begin
    gain_d = gain_q;
    sust_d = sust_q;
    case (state_q)
      ST_IDLE: begin
        gain_d = '0;
      end
      ST_ATTACK: begin
        if (!fall_c && tick_c) begin
          gain_d = attack_gain_c;
          if (attack_full_c) sust_d = SUST_LOAD;
        end
      end
      ST_SUSTAIN: begin
        gain_d = 8'hFF;
        if (fall_c) begin
          sust_d = sust_q;
        end else if (rise_c) begin
          sust_d = SUST_LOAD;
        end else if (tick_c) begin
          sust_d = sust_last_c ? '0 : SUST_W'(sust_q - SUST_W'(1));
        end
      end
      ST_DECAY: begin
        if (!rise_c && tick_c) gain_d = decay_gain_c;
      end
      default: begin
        gain_d = '0;
        sust_d = '0;
      end
    endcase
  end

  // Datapath registers; active tracks the registered state exactly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gain_q   <= '0;
      sust_q   <= '0;
      wave_q   <= '0;
      active_q <= 1'b0;
    end else begin
      gain_q   <= gain_d;
      sust_q   <= sust_d;
      wave_q   <= wave_d;
      active_q <= (state_d != ST_IDLE);
    end
  end

  assign wave_out = wave_q;
  assign gain     = gain_q;
  assign state    = state_q;
  assign active   = active_q;

endmodule

// File: tb/tb_voice_envelope.sv
// Directed bench for voice_envelope with small timing parameters.
module tb_voice_envelope;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_ATT  = 2'b01;
  localparam logic [1:0] S_SUS  = 2'b10;
  localparam logic [1:0] S_DEC  = 2'b11;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] note_in;
  logic       key_on;
  logic [7:0] wave_out;
  logic [7:0] gain;
  logic [1:0] state;
  logic       active;

  int n_chk  = 0;
  int n_pass = 0;

  voice_envelope #(
    .TICK_DIV     (4),
    .ATTACK_STEP  (64),
    .DECAY_STEP   (32),
    .SUSTAIN_TICKS(2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .note_in (note_in),
    .key_on  (key_on),
    .wave_out(wave_out),
    .gain    (gain),
    .state   (state),
    .active  (active)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       key;
    logic [7:0] note;
    int         ncyc;
    logic [1:0] st;
    logic [7:0] g;
    logic       act;
    logic [7:0] w;
  } vec_t;

  vec_t vecs[$];

  task automatic cmp(input string name, input logic [15:0] act_v, input logic [15:0] exp_v);
    n_chk++;
    if (act_v === exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act_v, exp_v);
  endtask

  task automatic check(input string name, input logic [1:0] st, input logic [7:0] g,
                       input logic act, input logic chk_w, input logic [7:0] w);
    cmp({name, ".state"},  16'(state),  16'(st));
    cmp({name, ".gain"},   16'(gain),   16'(g));
    cmp({name, ".active"}, 16'(active), 16'(act));
    if (chk_w) cmp({name, ".wave"}, 16'(wave_out), 16'(w));
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Holds reset for two edges, checks reset values, releases just after an edge.
  task automatic do_reset(input logic key);
    reset_n = 1'b0;
    key_on  = key;
    #1;
    check("reset", S_IDLE, 8'd0, 1'b0, 1'b1, 8'd0);
    cycles(2);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b1;
    key_on  = 1'b0;
    note_in = 8'd200;
    #2;

    // Full held-key envelope; ticks land on every 4th edge after release.
    vecs.push_back('{"att_enter", 1'b1, 8'd200, 1, S_ATT, 8'd0,   1'b1, 8'd0});
    vecs.push_back('{"att_t1",    1'b1, 8'd200, 3, S_ATT, 8'd64,  1'b1, 8'd0});
    vecs.push_back('{"att_t2",    1'b1, 8'd200, 4, S_ATT, 8'd128, 1'b1, 8'd50});
    vecs.push_back('{"att_t3",    1'b1, 8'd200, 4, S_ATT, 8'd192, 1'b1, 8'd100});
    vecs.push_back('{"att_t4",    1'b1, 8'd200, 4, S_SUS, 8'd255, 1'b1, 8'd150});
    vecs.push_back('{"sus_t1",    1'b1, 8'd200, 4, S_SUS, 8'd255, 1'b1, 8'd199});
    vecs.push_back('{"sus_t2",    1'b1, 8'd200, 4, S_DEC, 8'd255, 1'b1, 8'd199});
    vecs.push_back('{"dec_pre",   1'b1, 8'd200, 3, S_DEC, 8'd255, 1'b1, 8'd199});
    vecs.push_back('{"dec_t1",    1'b1, 8'd200, 1, S_DEC, 8'd223, 1'b1, 8'd199});
    vecs.push_back('{"dec_t2",    1'b1, 8'd200, 4, S_DEC, 8'd191, 1'b1, 8'd174});
    vecs.push_back('{"dec_t3",    1'b1, 8'd200, 4, S_DEC, 8'd159, 1'b1, 8'd149});
    vecs.push_back('{"dec_t4",    1'b1, 8'd200, 4, S_DEC, 8'd127, 1'b1, 8'd124});
    vecs.push_back('{"dec_t5",    1'b1, 8'd200, 4, S_DEC, 8'd95,  1'b1, 8'd99});
    vecs.push_back('{"dec_t6",    1'b1, 8'd200, 4, S_DEC, 8'd63,  1'b1, 8'd74});
    vecs.push_back('{"dec_t7",    1'b1, 8'd200, 4, S_DEC, 8'd31,  1'b1, 8'd49});
    vecs.push_back('{"dec_pre0",  1'b1, 8'd200, 3, S_DEC, 8'd31,  1'b1, 8'd24});
    vecs.push_back('{"dec_t8",    1'b1, 8'd200, 1, S_IDLE, 8'd0,  1'b0, 8'd24});
    vecs.push_back('{"idle_held", 1'b1, 8'd200, 4, S_IDLE, 8'd0,  1'b0, 8'd0});

    @(posedge clk);
    #1;
    do_reset(1'b0);
    for (int i = 0; i < vecs.size(); i++) begin
      key_on  = vecs[i].key;
      note_in = vecs[i].note;
      cycles(vecs[i].ncyc);
      check(vecs[i].name, vecs[i].st, vecs[i].g, vecs[i].act, 1'b1, vecs[i].w);
    end

    // Key already high at release; release in attack, re-press in decay.
    note_in = 8'd200;
    do_reset(1'b1);
    cycles(1);
    check("rel_att", S_ATT, 8'd0, 1'b1, 1'b0, 8'd0);
    cycles(7);
    check("att128", S_ATT, 8'd128, 1'b1, 1'b0, 8'd0);
    key_on = 1'b0;
    cycles(1);
    check("fall_att", S_DEC, 8'd128, 1'b1, 1'b0, 8'd0);
    cycles(3);
    check("dec96", S_DEC, 8'd96, 1'b1, 1'b0, 8'd0);
    key_on = 1'b1;
    cycles(1);
    check("rise_dec", S_ATT, 8'd96, 1'b1, 1'b0, 8'd0);
    cycles(3);
    check("re_att160", S_ATT, 8'd160, 1'b1, 1'b0, 8'd0);
    cycles(4);
    check("re_att224", S_ATT, 8'd224, 1'b1, 1'b0, 8'd0);
    cycles(4);
    check("re_att255", S_SUS, 8'd255, 1'b1, 1'b0, 8'd0);

    // Fall on a tick edge: transition only, gain untouched.
    cycles(3);
    key_on = 1'b0;
    cycles(1);
    check("fall_tick", S_DEC, 8'd255, 1'b1, 1'b0, 8'd0);
    cycles(3);
    key_on = 1'b1;
    cycles(1);
    check("rise_tick", S_ATT, 8'd255, 1'b1, 1'b0, 8'd0);
    cycles(4);
    check("att_sat", S_SUS, 8'd255, 1'b1, 1'b0, 8'd0);

    // Asynchronous reset mid-sustain, away from any clock edge.
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst", S_IDLE, 8'd0, 1'b0, 1'b1, 8'd0);
    note_in = 8'd255;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cycles(1);
    check("post_rst", S_ATT, 8'd0, 1'b1, 1'b1, 8'd0);
    cycles(7);
    check("w255_128", S_ATT, 8'd128, 1'b1, 1'b1, 8'd63);
    cycles(8);
    check("w255_sus", S_SUS, 8'd255, 1'b1, 1'b1, 8'd191);
    cycles(1);
    check("w255_255", S_SUS, 8'd255, 1'b1, 1'b1, 8'd254);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
